song_sequencer: RTL and testbench

SONG_SEQUENCER -- requirements
Module: song_sequencer

---
 rtl/song_sequencer_pkg.sv | 35 +++
 rtl/song_sequencer_rom.sv | 21 ++
 rtl/song_sequencer.sv | 138 +++++++++++++
 tb/tb_song_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/song_sequencer_pkg.sv
// Shared note parameters: note codes, ROM entry layout and sequencer state encoding.
// Used by the sequencer, its song ROM and the piano top.
package song_sequencer_pkg;

  localparam int unsigned NOTE_W = 4;
  localparam int unsigned DUR_W  = 4;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd8;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } song_entry_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_PLAY  = 2'd1,
    SEQ_PAUSE = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_e;

  // Codes above C5 are not playable and are heard as silence.
  function automatic logic [NOTE_W-1:0] playable_note(input logic [NOTE_W-1:0] code);
    return (code > NOTE_C5) ? NOTE_REST : code;
  endfunction

endpackage

// File: rtl/song_sequencer_rom.sv
// Combinational song ROM: address in, {note,dur} entry out; dur==0 marks song end.
module song_rom
  import song_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] addr,
  output song_entry_t       entry
);

  always_comb begin
    entry = '0;
    case (addr)
      ADDR_W'(0): entry = '{note: NOTE_C4, dur: DUR_W'(2)};
      ADDR_W'(1): entry = '{note: NOTE_E4, dur: DUR_W'(1)};
      ADDR_W'(2): entry = '{note: NOTE_G4, dur: DUR_W'(3)};
      default:    entry = '0;
    endcase
  end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: steps through song_rom on eighth-beat ticks and drives auto_note.
// Optional macro SEQ_ARTIC_GAP_EN rests during the last tick of notes lasting >=2 ticks.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12_500_000,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              STOP,
  input  logic              PAUSE,
  input  logic              LOOP,
  output logic [NOTE_W-1:0] note,
  output logic [ADDR_W-1:0] pos,
  output logic              playing,
  output logic              done
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] POS_LAST = '1;

  seq_state_e        state;
  logic [CNT_W-1:0]  tick_cnt;
  logic [DUR_W-1:0]  remaining;
  logic [NOTE_W-1:0] cur_note;
  logic              in_gap;

  song_entry_t       first_entry;
  song_entry_t       next_entry;
  logic [ADDR_W-1:0] next_addr_c;
  logic              run_c;
  logic              tick_c;
  logic              song_end_c;

  assign next_addr_c = pos + ADDR_W'(1);

  song_rom #(.ADDR_W(ADDR_W)) u_rom_first (
    .addr  ('0),
    .entry (first_entry)
  );

  song_rom #(.ADDR_W(ADDR_W)) u_rom_next (
    .addr  (next_addr_c),
    .entry (next_entry)
  );

  // A PAUSE pulse while paused resumes and counts that same cycle, so the
  // delay seen downstream equals the number of cycles spent paused.
  assign run_c      = ((state == SEQ_PLAY) && !PAUSE) || ((state == SEQ_PAUSE) && PAUSE);
  assign tick_c     = (tick_cnt == CNT_LAST);
  assign song_end_c = (pos == POS_LAST) || (next_entry.dur == '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= SEQ_IDLE;
      tick_cnt  <= '0;
      remaining <= '0;
      cur_note  <= NOTE_REST;
      in_gap    <= 1'b0;
      note      <= NOTE_REST;
      pos       <= '0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (STOP) begin
        state     <= SEQ_IDLE;
        tick_cnt  <= '0;
        remaining <= '0;
        in_gap    <= 1'b0;
        note      <= NOTE_REST;
        pos       <= '0;
        playing   <= 1'b0;
      end else if (START) begin
        tick_cnt <= '0;
        pos      <= '0;
        in_gap   <= 1'b0;
        cur_note <= playable_note(first_entry.note);
        if (first_entry.dur == '0) begin
          state     <= SEQ_DONE;
          remaining <= '0;
          note      <= NOTE_REST;
          playing   <= 1'b0;
          done      <= 1'b1;
        end else begin
          state     <= SEQ_PLAY;
          remaining <= first_entry.dur;
          note      <= playable_note(first_entry.note);
          playing   <= 1'b1;
        end
      end else if (PAUSE && (state == SEQ_PLAY)) begin
        state   <= SEQ_PAUSE;
        note    <= NOTE_REST;
        playing <= 1'b0;
      end else if (run_c) begin
        state    <= SEQ_PLAY;
        playing  <= 1'b1;
        tick_cnt <= tick_c ? '0 : tick_cnt + CNT_W'(1);
        note     <= in_gap ? NOTE_REST : cur_note;
        if (tick_c) begin
          if (remaining > DUR_W'(1)) begin
            remaining <= remaining - DUR_W'(1);
`ifdef SEQ_ARTIC_GAP_EN
            if (remaining == DUR_W'(2)) begin
              in_gap <= 1'b1;
              note   <= NOTE_REST;
            end
`endif
          end else begin
            in_gap <= 1'b0;
            if (!song_end_c) begin
              pos       <= next_addr_c;
              remaining <= next_entry.dur;
              cur_note  <= playable_note(next_entry.note);
              note      <= playable_note(next_entry.note);
            end else if (LOOP && (first_entry.dur != '0)) begin
              pos       <= '0;
              remaining <= first_entry.dur;
              cur_note  <= playable_note(first_entry.note);
              note      <= playable_note(first_entry.note);
            end else begin
              state     <= SEQ_DONE;
              tick_cnt  <= '0;
              remaining <= '0;
              note      <= NOTE_REST;
              playing   <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer (TICK_DIV=4): vector table replayed through a scoreboard.
// Expectations follow SEQ_ARTIC_GAP_EN when the bench is built with it.
module tb_song_sequencer;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned ADDR_W   = 6;
`ifdef SEQ_ARTIC_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              START = 1'b0;
  logic              STOP = 1'b0;
  logic              PAUSE = 1'b0;
  logic              LOOP = 1'b0;
  logic [3:0]        note;
  logic [ADDR_W-1:0] pos;
  logic              playing;
  logic              done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic              rst, start, stop, pause, loop;
    logic [3:0]        note;
    logic [ADDR_W-1:0] pos;
    logic              playing, done;
  } vec_t;

  typedef struct {
    logic [3:0]        note;
    logic [ADDR_W-1:0] pos;
    logic              playing, done;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  song_sequencer #(.TICK_DIV(TICK_DIV), .ADDR_W(ADDR_W)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START   (START),
    .STOP    (STOP),
    .PAUSE   (PAUSE),
    .LOOP    (LOOP),
    .note    (note),
    .pos     (pos),
    .playing (playing),
    .done    (done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] g(input logic [3:0] n);
    return GAP ? 4'd0 : n;
  endfunction

  function automatic void add(input int n, input logic rst, input logic st, input logic sp,
                              input logic pa, input logic lp, input logic [3:0] nt,
                              input logic [ADDR_W-1:0] p, input logic pl, input logic dn);
    for (int i = 0; i < n; i++) tbl.push_back('{rst, st, sp, pa, lp, nt, p, pl, dn});
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[%0d] got %0d want %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    int   n;

    // reset
    add(2, 1,0,0,0,0, 0,0,0,0);
    // plain run to the end marker
    add(1, 0,1,0,0,0, 1,0,1,0);
    add(3, 0,0,0,0,0, 1,0,1,0);
    add(4, 0,0,0,0,0, g(1),0,1,0);
    add(4, 0,0,0,0,0, 3,1,1,0);
    add(8, 0,0,0,0,0, 5,2,1,0);
    add(4, 0,0,0,0,0, g(5),2,1,0);
    add(1, 0,0,0,0,0, 0,2,0,1);
    add(1, 0,0,0,0,0, 0,2,0,0);
    add(1, 0,0,0,1,0, 0,2,0,0);
    add(1, 0,0,1,0,0, 0,0,0,0);
    // LOOP wraps to entry 0 without done
    add(1, 0,1,0,0,1, 1,0,1,0);
    add(3, 0,0,0,0,1, 1,0,1,0);
    add(4, 0,0,0,0,1, g(1),0,1,0);
    add(4, 0,0,0,0,1, 3,1,1,0);
    add(8, 0,0,0,0,1, 5,2,1,0);
    add(4, 0,0,0,0,1, g(5),2,1,0);
    add(1, 0,0,0,0,1, 1,0,1,0);
    add(3, 0,0,0,0,1, 1,0,1,0);
    add(1, 0,0,1,0,1, 0,0,0,0);
    // pause for 20 cycles delays everything by 20
    add(1, 0,1,0,0,0, 1,0,1,0);
    add(2, 0,0,0,0,0, 1,0,1,0);
    add(1, 0,0,0,1,0, 0,0,0,0);
    add(19, 0,0,0,0,0, 0,0,0,0);
    add(1, 0,0,0,1,0, 1,0,1,0);
    add(4, 0,0,0,0,0, g(1),0,1,0);
    add(1, 0,0,0,0,0, 3,1,1,0);
    add(1, 0,0,1,0,0, 0,0,0,0);
    add(1, 0,0,0,1,0, 0,0,0,0);
    // STOP beats START, then START restarts
    add(1, 0,1,0,0,0, 1,0,1,0);
    add(3, 0,0,0,0,0, 1,0,1,0);
    add(4, 0,0,0,0,0, g(1),0,1,0);
    add(1, 0,0,0,0,0, 3,1,1,0);
    add(1, 0,1,1,0,0, 0,0,0,0);
    add(1, 0,1,0,0,0, 1,0,1,0);
    // RESET mid-note beats START, no done afterwards
    add(2, 0,0,0,0,0, 1,0,1,0);
    add(1, 1,1,0,0,0, 0,0,0,0);
    add(30, 0,0,0,0,0, 0,0,0,0);

    foreach (tbl[i]) begin
      RESET = tbl[i].rst;
      START = tbl[i].start;
      STOP  = tbl[i].stop;
      PAUSE = tbl[i].pause;
      LOOP  = tbl[i].loop;
      sb.push_back('{tbl[i].note, tbl[i].pos, tbl[i].playing, tbl[i].done});
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      check("note", i, int'(note), int'(e.note));
      check("pos", i, int'(pos), int'(e.pos));
      check("playing", i, int'(playing), int'(e.playing));
      check("done", i, int'(done), int'(e.done));
    end

    // song length: done must appear exactly 24 cycles after the START edge
    RESET = 1'b0; STOP = 1'b0; PAUSE = 1'b0; LOOP = 1'b0;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("done_latency", 0, n, 24);
    check("done_note", 0, int'(note), 0);
    @(posedge CLK);
    #1;
    check("done_width", 0, int'(done), 0);
    check("done_state_note", 0, int'(note), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
